// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles every non-clock signal of the instruction-fetch stage.
//   master : fetch_stage side. Receives hazard/redirect/imem data and drives
//            imem_addr plus the IF/ID register outputs.
//   slave  : environment side (hazard unit, branch unit, instruction memory,
//            decode stage).
// Signals:
//   stall, redirect_valid, redirect_target : pipeline control into fetch
//   imem_addr / imem_instr                 : combinational instruction memory port
//   ifid_pc, ifid_instr, ifid_valid        : IF/ID pipeline register
//   halted, misalign_err                   : status
interface fetch_stage_if #(
  parameter int XLEN = 64
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic [XLEN-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;
  logic            halted;
  logic            misalign_err;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_instr,
    output imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, misalign_err
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_instr,
    input  imem_addr, ifid_pc, ifid_instr, ifid_valid, halted, misalign_err
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined RISC-V core.
// Owns the PC, presents it as the instruction-memory byte address, and
// captures the returned word into the IF/ID register. Handles hazard stalls,
// branch redirects (with IF/ID flush) and halts once the PC leaves the
// populated instruction range.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : fetch_stage_if.master (control in, imem port, IF/ID and status out)
module fetch_stage #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [XLEN-1:0] IMEM_BYTES = XLEN'(160),
  parameter logic [31:0]     NOP_INSTR  = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master bus
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (RESET_PC >= IMEM_BYTES) ? S_HALT : S_FETCH;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic            halted_q, halted_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] target_aligned;

  assign pc_plus4       = pc_q + XLEN'(4);
  assign target_aligned = {bus.redirect_target[XLEN-1:2], 2'b00};

  // Priority: redirect, then stall, then the per-state normal edge.
  // halted follows the next state so it rises on the edge that loads the
  // last in-range instruction and drops on the redirect edge leaving HALT.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    halted_d     = halted_q;
    misalign_d   = misalign_q;

    if (bus.redirect_valid) begin
      pc_d         = target_aligned;
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_INSTR;
      if (bus.redirect_target[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
      state_d  = (target_aligned >= IMEM_BYTES) ? S_HALT : S_FETCH;
      halted_d = (target_aligned >= IMEM_BYTES);
    end else if (!bus.stall) begin
      unique case (state_q)
        S_FETCH: begin
          ifid_instr_d = bus.imem_instr;
          ifid_pc_d    = pc_q;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          state_d      = (pc_plus4 >= IMEM_BYTES) ? S_HALT : S_FETCH;
          halted_d     = (pc_plus4 >= IMEM_BYTES);
        end
        S_HALT: begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
          halted_d     = 1'b1;
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      misalign_q   <= misalign_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.ifid_pc      = ifid_pc_q;
  assign bus.ifid_instr   = ifid_instr_q;
  assign bus.ifid_valid   = ifid_valid_q;
  assign bus.halted       = halted_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan sequence followed by randomized
// stall/redirect/reset traffic, all checked against a behavioural model of
// the fetch stage (halt is derived from the PC being outside the image).
module tb_fetch_stage;

  localparam logic [63:0] IMEM_BYTES = 64'd160;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  fetch_stage_if #(.XLEN(64)) bus ();

  fetch_stage #(
    .XLEN      (64),
    .RESET_PC  (64'd0),
    .IMEM_BYTES(IMEM_BYTES),
    .NOP_INSTR (NOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Program image and combinational instruction memory.
  logic [31:0] image [0:63];

  always_comb begin
    if (bus.imem_addr < IMEM_BYTES) bus.imem_instr = image[bus.imem_addr[7:2]];
    else                            bus.imem_instr = 32'hDEAD_BEEF;
  end

  // Reference model state.
  logic [63:0] m_pc, m_ifid_pc;
  logic [31:0] m_instr;
  logic        m_valid, m_halted, m_mis;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_addr"},  bus.imem_addr, m_pc);
    check({tag, ".ifid_pc"},    bus.ifid_pc, m_ifid_pc);
    check({tag, ".ifid_instr"}, 64'(bus.ifid_instr), 64'(m_instr));
    check({tag, ".ifid_valid"}, 64'(bus.ifid_valid), 64'(m_valid));
    check({tag, ".halted"},     64'(bus.halted), 64'(m_halted));
    check({tag, ".misalign"},   64'(bus.misalign_err), 64'(m_mis));
  endtask

  task automatic model_reset();
    m_pc      = 64'd0;
    m_ifid_pc = 64'd0;
    m_instr   = NOP;
    m_valid   = 1'b0;
    m_halted  = 1'b0;
    m_mis     = 1'b0;
  endtask

  // One clock edge of the fetch stage, expressed directly from its rules.
  task automatic model_edge(input logic s, input logic rv, input logic [63:0] tgt);
    if (rv) begin
      m_pc     = tgt & ~64'd3;
      m_valid  = 1'b0;
      m_instr  = NOP;
      m_mis    = m_mis | (tgt[1:0] != 2'b00);
      m_halted = (m_pc >= IMEM_BYTES);
    end else if (!s) begin
      if (m_pc < IMEM_BYTES) begin
        m_instr   = image[m_pc[7:2]];
        m_ifid_pc = m_pc;
        m_valid   = 1'b1;
        m_pc      = m_pc + 64'd4;
        m_halted  = (m_pc >= IMEM_BYTES);
      end else begin
        m_valid  = 1'b0;
        m_instr  = NOP;
        m_halted = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic s, input logic rv, input logic [63:0] tgt);
    bus.stall           = s;
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    @(posedge clk);
    model_edge(s, rv, tgt);
    #1;
    check_all("cyc");
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    #2;
    reset = 1'b0;
  endtask

  initial begin
    logic [63:0] tgt;
    int unsigned kind;

    for (int i = 0; i < 64; i++) image[i] = (i < 40) ? $urandom : 32'h0;
    image[0]  = 32'h0040_0593;
    image[1]  = 32'h0000_0313;
    image[2]  = 32'h0000_0393;
    image[4]  = 32'h08b3_0863;
    image[30] = 32'h0007_3803;
    image[39] = 32'hfa00_04e3;

    bus.stall           = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;

    // Power-on reset.
    #1 reset = 1'b1;
    model_reset();
    #2;
    check_all("reset");
    #4 reset = 1'b0;

    // Sequential fetch.
    cycle(0, 0, 0);
    check("seq1.pc", bus.ifid_pc, 64'd0);
    check("seq1.instr", 64'(bus.ifid_instr), 64'h0040_0593);
    cycle(0, 0, 0);
    check("seq2.instr", 64'(bus.ifid_instr), 64'h0000_0313);
    check("seq2.addr", bus.imem_addr, 64'd8);

    // Stall holds everything.
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0);
      check("stall.addr", bus.imem_addr, 64'd8);
      check("stall.pc", bus.ifid_pc, 64'd4);
    end
    cycle(0, 0, 0);
    check("unstall.pc", bus.ifid_pc, 64'd8);
    check("unstall.instr", 64'(bus.ifid_instr), 64'h0000_0393);

    // Redirect wins over a simultaneous stall.
    cycle(1, 1, 64'h10);
    check("redir.valid", 64'(bus.ifid_valid), 64'd0);
    check("redir.addr", bus.imem_addr, 64'h10);
    cycle(0, 0, 0);
    check("redir.tgt_instr", 64'(bus.ifid_instr), 64'h08b3_0863);

    // Run to the end of the image.
    for (int k = 0; k < 60 && !m_halted; k++) cycle(0, 0, 0);
    check("eop.halted", 64'(bus.halted), 64'd1);
    check("eop.pc", bus.ifid_pc, 64'd156);
    check("eop.instr", 64'(bus.ifid_instr), 64'hfa00_04e3);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0);
      check("halt.addr", bus.imem_addr, 64'd160);
      check("halt.valid", 64'(bus.ifid_valid), 64'd0);
    end
    cycle(0, 1, 64'h78);
    check("unhalt.halted", 64'(bus.halted), 64'd0);
    cycle(0, 0, 0);
    check("unhalt.instr", 64'(bus.ifid_instr), 64'h0007_3803);

    // Misaligned and out-of-range redirects.
    cycle(0, 1, 64'h22);
    check("mis.addr", bus.imem_addr, 64'h20);
    check("mis.flag", 64'(bus.misalign_err), 64'd1);
    cycle(0, 0, 0);
    cycle(0, 1, 64'h30);
    check("mis.sticky", 64'(bus.misalign_err), 64'd1);
    cycle(0, 1, 64'h200);
    check("oor.halted", 64'(bus.halted), 64'd1);
    cycle(0, 0, 0);
    check("oor.valid", 64'(bus.ifid_valid), 64'd0);

    // Asynchronous reset mid-run.
    cycle(0, 1, 64'h40);
    do_reset();
    cycle(0, 0, 0);
    check("post_rst.pc", bus.ifid_pc, 64'd0);
    check("post_rst.instr", 64'(bus.ifid_instr), 64'h0040_0593);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 50) do_reset();
      kind = $urandom_range(0, 3);
      case (kind)
        0:       tgt = 64'($urandom_range(0, 39)) * 64'd4;
        1:       tgt = 64'($urandom_range(0, 159));
        2:       tgt = 64'($urandom_range(160, 1023));
        default: tgt = {$urandom, $urandom};
      endcase
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
